// File: rtl/seg7_dynamic_to_static.sv
// seg7_dynamic_to_static
//   Converts a multiplexed 7-segment stream into static per-digit drives.
//   Each selected digit captures the incoming pattern into a store register.
//   The store then feeds one output register stage that applies PWM gating
//   and output polarity.
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   mode            0 = sticky (hold last capture), 1 = transparent
//   abcdefgh        positive-logic segments, MSB = a, bit 0 = dp
//   digit           positive-logic digit strobes, multi-hot allowed
//   brightness      PWM duty, 0 = off, all-ones = full on
//   clear           synchronous blank-all
//   seg_out         digit i at [i*w_seg +: w_seg], field bit 0 = a
//   dp_out          per-digit decimal point
//   stale           1 = digit holds no valid or fresh data
module seg7_dynamic_to_static #(
    parameter int w_digit        = 8,
    parameter int w_seg          = 7,
    parameter bit seg_active_low = 1'b1,
    parameter bit dp_active_low  = 1'b0,
    parameter int w_bright       = 4,
    parameter int timeout_cycles = 50000000,
    parameter int w_timeout      = (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mode,
    input  logic [w_seg:0]             abcdefgh,
    input  logic [w_digit-1:0]         digit,
    input  logic [w_bright-1:0]        brightness,
    input  logic                       clear,
    output logic [w_digit*w_seg-1:0]   seg_out,
    output logic [w_digit-1:0]         dp_out,
    output logic [w_digit-1:0]         stale
);

    localparam logic [w_timeout-1:0] t_max  = w_timeout'(timeout_cycles);
    localparam logic [w_bright-1:0]  b_full = '1;

    logic [w_digit-1:0][w_seg-1:0]     seg_store_q, seg_store_d;
    logic [w_digit-1:0]                dp_store_q, dp_store_d;
    logic [w_digit-1:0]                stale_q, stale_d;
    logic [w_digit-1:0][w_timeout-1:0] cnt_q, cnt_d;
    logic [w_bright-1:0]               pwm_cnt_q, pwm_cnt_d;
    logic [w_digit*w_seg-1:0]          seg_out_q, seg_out_d;
    logic [w_digit-1:0]                dp_out_q, dp_out_d;

    logic [w_seg-1:0] cap_seg;
    logic [w_seg-1:0] lit_seg;
    logic             pwm_on;

    always_comb begin
        // Input is a-first from the MSB; fields are a-first from bit 0.
        for (int j = 0; j < w_seg; j++) cap_seg[j] = abcdefgh[w_seg - j];

        pwm_on    = (brightness == b_full) || (pwm_cnt_q < brightness);
        pwm_cnt_d = pwm_cnt_q + w_bright'(1);

        seg_store_d = seg_store_q;
        dp_store_d  = dp_store_q;
        stale_d     = stale_q;
        cnt_d       = cnt_q;
        seg_out_d   = '0;
        dp_out_d    = '0;
        lit_seg     = '0;

        for (int i = 0; i < w_digit; i++) begin
            // Priority: clear, then strobe capture, then timeout blanking.
            if (clear) begin
                seg_store_d[i] = '0;
                dp_store_d[i]  = 1'b0;
                stale_d[i]     = 1'b1;
                cnt_d[i]       = t_max;
            end else if (digit[i]) begin
                seg_store_d[i] = cap_seg;
                dp_store_d[i]  = abcdefgh[0];
                stale_d[i]     = 1'b0;
                cnt_d[i]       = '0;
            end else begin
                if (mode) begin
                    seg_store_d[i] = '0;
                    dp_store_d[i]  = 1'b0;
                end
                if (timeout_cycles != 0) begin
                    cnt_d[i] = (cnt_q[i] == t_max) ? t_max : cnt_q[i] + w_timeout'(1);
                    if (cnt_d[i] == t_max) begin
                        seg_store_d[i] = '0;
                        dp_store_d[i]  = 1'b0;
                        stale_d[i]     = 1'b1;
                    end
                end
            end

            lit_seg = seg_store_q[i] & {w_seg{pwm_on}};
            seg_out_d[i*w_seg +: w_seg] = seg_active_low ? ~lit_seg : lit_seg;
            dp_out_d[i] = (dp_store_q[i] & pwm_on) ^ dp_active_low;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_store_q <= '0;
            dp_store_q  <= '0;
            stale_q     <= '1;
            cnt_q       <= {w_digit{t_max}};
            pwm_cnt_q   <= '0;
            seg_out_q   <= {(w_digit*w_seg){seg_active_low}};
            dp_out_q    <= {w_digit{dp_active_low}};
        end else begin
            seg_store_q <= seg_store_d;
            dp_store_q  <= dp_store_d;
            stale_q     <= stale_d;
            cnt_q       <= cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            seg_out_q   <= seg_out_d;
            dp_out_q    <= dp_out_d;
        end
    end

    assign seg_out = seg_out_q;
    assign dp_out  = dp_out_q;
    assign stale   = stale_q;

endmodule

// File: tb/tb_seg7_dynamic_to_static.sv
module tb_seg7_dynamic_to_static;

    localparam int ND = 8;
    localparam int NS = 7;
    localparam int TO = 16;

    logic              clk, rst, mode, clear;
    logic [NS:0]       abcdefgh;
    logic [ND-1:0]     digit;
    logic [3:0]        brightness;
    logic [ND*NS-1:0]  seg_out;
    logic [ND-1:0]     dp_out, stale;

    seg7_dynamic_to_static #(.timeout_cycles(TO)) dut (
        .clk(clk), .rst(rst), .mode(mode), .abcdefgh(abcdefgh), .digit(digit),
        .brightness(brightness), .clear(clear), .seg_out(seg_out),
        .dp_out(dp_out), .stale(stale)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [ND*NS-1:0] seg;
        logic [ND-1:0]    dp;
        logic [ND-1:0]    stl;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: stored fields in positive logic, a at bit 0.
    logic [NS-1:0] m_seg[ND];
    logic          m_dp[ND];
    logic          m_stale[ND];
    int            m_cnt[ND];
    int            m_pwm;

    task automatic model_reset();
        for (int i = 0; i < ND; i++) begin
            m_seg[i] = '0; m_dp[i] = 1'b0; m_stale[i] = 1'b1; m_cnt[i] = TO;
        end
        m_pwm = 0;
        exp_q.delete();
    endtask

    // Drive one cycle at the falling edge and queue the outputs expected after the next rising edge.
    task automatic cycle(input logic m, input logic [7:0] s, input logic [7:0] d,
                         input logic [3:0] b, input logic c);
        exp_t e;
        logic lit;
        mode = m; abcdefgh = s; digit = d; brightness = b; clear = c;
        lit = (b == 4'hF) || (m_pwm < int'(b));
        for (int i = 0; i < ND; i++) begin
            e.seg[i*NS +: NS] = ~(lit ? m_seg[i] : 7'h00);
            e.dp[i] = lit & m_dp[i];
        end
        m_pwm = (m_pwm + 1) % 16;
        for (int i = 0; i < ND; i++) begin
            if (c) begin
                m_seg[i] = '0; m_dp[i] = 1'b0; m_stale[i] = 1'b1; m_cnt[i] = TO;
            end else if (d[i]) begin
                for (int j = 0; j < NS; j++) m_seg[i][j] = s[7-j];
                m_dp[i] = s[0]; m_stale[i] = 1'b0; m_cnt[i] = 0;
            end else begin
                if (m) begin m_seg[i] = '0; m_dp[i] = 1'b0; end
                if (m_cnt[i] < TO) m_cnt[i]++;
                if (m_cnt[i] == TO) begin
                    m_seg[i] = '0; m_dp[i] = 1'b0; m_stale[i] = 1'b1;
                end
            end
            e.stl[i] = m_stale[i];
        end
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Scoreboard consumer: compares every queued expectation just after the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (seg_out !== e.seg) begin
                    errors++;
                    $display("FAIL sb_seg got %h want %h at %0t", seg_out, e.seg, $time);
                end
                checks++;
                if (dp_out !== e.dp) begin
                    errors++;
                    $display("FAIL sb_dp got %h want %h at %0t", dp_out, e.dp, $time);
                end
                checks++;
                if (stale !== e.stl) begin
                    errors++;
                    $display("FAIL sb_stale got %h want %h at %0t", stale, e.stl, $time);
                end
            end
        end
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (seg_out !== 56'hFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL rst_seg got %h want ff_ffff_ffff_ffff", seg_out); end
        checks++;
        if (dp_out !== 8'h00) begin errors++; $display("FAIL rst_dp got %h want 00", dp_out); end
        checks++;
        if (stale !== 8'hFF) begin errors++; $display("FAIL rst_stale got %h want ff", stale); end
        rst = 1'b0;
        model_reset();
        cycle(0, 8'hFD, 8'h01, 4'hF, 0);
        cycle(0, 8'hFD, 8'h00, 4'hF, 0);
        checks++;
        if (seg_out[6:0] !== 7'b100_0000) begin errors++; $display("FAIL pre_rst_field got %b want 1000000", seg_out[6:0]); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (seg_out !== 56'hFF_FFFF_FFFF_FFFF || stale !== 8'hFF || dp_out !== 8'h00) begin
            errors++;
            $display("FAIL async_rst got seg %h dp %h stale %h want all blank", seg_out, dp_out, stale);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sticky();
        cycle(0, 8'hFD, 8'h01, 4'hF, 0);
        checks++;
        if (stale[0] !== 1'b0) begin errors++; $display("FAIL sticky_stale got %b want 0", stale[0]); end
        for (int k = 0; k < 6; k++) begin
            cycle(0, 8'h00, 8'h00, 4'hF, 0);
            checks++;
            if (seg_out[6:0] !== 7'b100_0000 || dp_out[0] !== 1'b1 || seg_out[13:7] !== 7'h7F) begin
                errors++;
                $display("FAIL sticky_hold%0d got f0 %b dp %b f1 %h want 1000000 1 7f", k, seg_out[6:0], dp_out[0], seg_out[13:7]);
            end
        end
    endtask

    task automatic test_transparent();
        cycle(1, 8'hFD, 8'h01, 4'hF, 0);
        cycle(1, 8'hFD, 8'h00, 4'hF, 0);
        checks++;
        if (seg_out[6:0] !== 7'b100_0000) begin errors++; $display("FAIL transp_on got %b want 1000000", seg_out[6:0]); end
        cycle(1, 8'hFD, 8'h00, 4'hF, 0);
        checks++;
        if (seg_out[6:0] !== 7'h7F) begin errors++; $display("FAIL transp_off got %h want 7f", seg_out[6:0]); end
        cycle(1, 8'hFD, 8'h81, 4'hF, 0);
        cycle(1, 8'hFD, 8'h00, 4'hF, 0);
        checks++;
        if (seg_out[55:49] !== seg_out[6:0] || seg_out[55:49] !== 7'b100_0000) begin
            errors++;
            $display("FAIL transp_multi got f7 %b f0 %b want 1000000", seg_out[55:49], seg_out[6:0]);
        end
    endtask

    task automatic test_timeout();
        cycle(0, 8'hFD, 8'h01, 4'hF, 0);
        for (int k = 1; k <= TO - 1; k++) cycle(0, 8'h00, 8'h00, 4'hF, 0);
        checks++;
        if (stale[0] !== 1'b0) begin errors++; $display("FAIL to_early got %b want 0", stale[0]); end
        cycle(0, 8'h00, 8'h00, 4'hF, 0);
        checks++;
        if (stale[0] !== 1'b1) begin errors++; $display("FAIL to_stale got %b want 1", stale[0]); end
        cycle(0, 8'h00, 8'h00, 4'hF, 0);
        checks++;
        if (seg_out[6:0] !== 7'h7F) begin errors++; $display("FAIL to_blank got %h want 7f", seg_out[6:0]); end
        cycle(0, 8'hFD, 8'h01, 4'hF, 0);
        for (int k = 1; k <= 9; k++) cycle(0, 8'h00, 8'h00, 4'hF, 0);
        cycle(0, 8'hFD, 8'h01, 4'hF, 0);
        for (int k = 1; k <= TO - 1; k++) cycle(0, 8'h00, 8'h00, 4'hF, 0);
        checks++;
        if (stale[0] !== 1'b0 || seg_out[6:0] !== 7'b100_0000) begin
            errors++;
            $display("FAIL to_recap got stale %b f0 %b want 0 1000000", stale[0], seg_out[6:0]);
        end
    endtask

    task automatic pwm_run(input logic [3:0] b, input int n, input int want);
        int lit_cnt = 0;
        cycle(0, 8'hFD, 8'h01, b, 0);
        for (int k = 0; k < n; k++) begin
            cycle(0, 8'h00, 8'h00, b, 0);
            if (seg_out[6:0] !== 7'h7F) lit_cnt++;
        end
        checks++;
        if (lit_cnt != want) begin errors++; $display("FAIL pwm_b%0d got %0d lit want %0d", b, lit_cnt, want); end
    endtask

    task automatic test_pwm();
        pwm_run(4'd4, 16, 4);
        pwm_run(4'd0, 15, 0);
        pwm_run(4'd15, 15, 15);
    endtask

    task automatic test_clear();
        cycle(0, 8'hFD, 8'hFF, 4'hF, 0);
        cycle(0, 8'hFD, 8'hFF, 4'hF, 1);
        checks++;
        if (stale !== 8'hFF) begin errors++; $display("FAIL clr_stale got %h want ff", stale); end
        cycle(0, 8'h00, 8'h00, 4'hF, 0);
        checks++;
        if (seg_out !== 56'hFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL clr_blank got %h want all 7f", seg_out); end
        cycle(0, 8'hFD, 8'h04, 4'hF, 0);
        cycle(0, 8'h00, 8'h00, 4'hF, 0);
        checks++;
        if (seg_out[20:14] !== 7'b100_0000 || stale !== 8'hFB) begin
            errors++;
            $display("FAIL clr_resume got f2 %b stale %h want 1000000 fb", seg_out[20:14], stale);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 60; k++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                  4'($urandom), ($urandom_range(0, 15) == 0));
        end
        for (int k = 0; k < 20; k++) cycle(0, 8'h00, 8'h00, 4'hF, 0);
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; abcdefgh = '0; digit = '0; brightness = 4'hF; clear = 1'b0;
        model_reset();
        test_reset();
        test_sticky();
        test_transparent();
        test_timeout();
        test_pwm();
        test_clear();
        test_back_to_back();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_dynamic_to_static.md
Name: seg7_dynamic_to_static

Overview:
- Converts the multiplexed 7-segment stream produced by lab logic (abcdefgh plus a one-hot or multi-hot digit strobe) into per-digit static segment drives for boards with static displays.
- Generalises the sticky-flop approach: digit count, segment width and output polarity are parametrised.
- Adds runtime selection between sticky and transparent modes, per-digit stale timeout with blanking, PWM brightness control, and a synchronous clear.
- Sits in board-specific tops between lab_top and the HEX/LEDR pins.

Parameters:
- w_digit, 8, number of digits.
- w_seg, 7, segments per digit excluding dp.
- seg_active_low, 1, 1 = segment outputs are active-low.
- dp_active_low, 0, 1 = dp outputs are active-low.
- w_bright, 4, brightness/PWM counter width.
- timeout_cycles, 50000000, clk cycles without refresh before a digit is blanked; 0 = timeout disabled.
- w_timeout, $clog2(timeout_cycles+1), timeout counter width (derived).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- mode  input  1  0 = sticky, 1 = transparent.
- abcdefgh  input  w_seg+1  positive-logic segments; MSB = a, bit 1 = last segment, bit 0 = dp.
- digit  input  w_digit  positive-logic digit strobes; multi-hot allowed.
- brightness  input  w_bright  PWM duty: 0 = off, all-ones = full on.
- clear  input  1  synchronous blank-all request.
- seg_out  output  w_digit*w_seg  digit i occupies seg_out[i*w_seg +: w_seg]; field bit 0 = a, bit w_seg-1 = last segment (g).
- dp_out  output  w_digit  per-digit dp.
- stale  output  w_digit  1 = digit holds no valid or fresh data.

Behaviour:
- Pipeline: store registers (positive logic) feed one output register stage, so inputs sampled at edge k appear on the outputs after edge k+1. All outputs are flops.
- Reset (async):
  - store = all off; stale = all 1; timeout counters = timeout_cycles; pwm_cnt = 0.
  - seg_out = all 1 if seg_active_low, else all 0.
  - dp_out = all 1 if dp_active_low, else all 0.
- Sticky mode (mode = 0):
  - Each edge, every digit i with digit[i] = 1 loads abcdefgh (bit-reversed into field order), clears its counter and clears stale[i].
  - Digits with digit[i] = 0 hold their value.
  - digit = 0 means every digit holds.
- Transparent mode (mode = 1):
  - Selected digits load as in sticky mode.
  - Unselected digits load all-off; their counters and stale bits are not refreshed.
  - This mode is dim by design and exists for the dynamic-display demo lab.
- Mode change: takes effect on the next edge. Stored values are retained across the switch.
- Timeout:
  - Each unselected digit's counter increments and saturates at timeout_cycles.
  - On the edge the counter reaches timeout_cycles, that digit's store goes to off and stale[i] goes to 1.
  - A digit selected on the same edge wins over the timeout.
  - With timeout_cycles = 0, counters and timeout blanking are disabled; stale clears on the first capture and sets only on reset or clear.
- PWM:
  - pwm_cnt is free-running and wraps at 2^w_bright.
  - pwm_on = (brightness == all-ones) || (pwm_cnt < brightness).
  - Output stage drives store & pwm_on, then applies polarity. When pwm_on = 0, both segments and dp are off.
  - brightness changes take effect next edge, with no pwm_cnt reset.
- clear:
  - Blanks all stores, sets stale all 1, and sets counters to timeout_cycles.
  - Has priority over simultaneous digit strobes and timeouts.
- Width rules:
  - abcdefgh[w_seg - j] maps to field bit j for j = 0..w_seg-1.
  - abcdefgh[0] maps to dp.

Test Plan:
1. Reset with w_digit = 8, w_seg = 7 defaults -> seg_out = 56'hFF_FFFF_FFFF_FFFF, dp_out = 8'h00, stale = 8'hFF; async assert mid-capture blanks immediately.
2. Sticky capture:
   - Stimulus: mode 0, brightness 4'hF, abcdefgh = 8'b1111_1101, digit = 8'h01 for 1 cycle, then 0.
   - Required: seg_out[6:0] = 7'b100_0000 and dp_out[0] = 1 from edge k+1 onward and held; stale[0] = 0; digit 1 field stays 7'h7F.
3. Transparent mode:
   - Stimulus: mode 1, same single pulse.
   - Required: seg_out[6:0] = 7'b100_0000 for exactly one cycle, then 7'h7F.
   - Multi-hot strobe digit = 8'h81 -> fields 0 and 7 are identical.
4. Timeout:
   - Stimulus: timeout_cycles = 16, capture digit 0, then idle.
   - Required: stale[0] = 1 and field = 7'h7F after 16 cycles.
   - Recapture at idle cycle 10 -> no blanking up to cycle 16.
5. PWM:
   - brightness = 4 -> digit lit exactly 4 of every 16 cycles.
   - brightness = 0 -> never lit.
   - brightness = 15 -> always lit.
6. clear:
   - Stimulus: clear asserted together with digit = 8'hFF.
   - Required: all fields 7'h7F, stale = 8'hFF; capture resumes on the next strobe.
